bridge_gate_sched: RTL and testbench

BRIDGE_GATE_SCHED -- requirements
Module: bridge_gate_sched

---
 rtl/bridge_gate_sched.sv | 203 ++++++++++++++++++++
 tb/tb_bridge_gate_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bridge_gate_sched.sv
// ============================================================================
// Module   : bridge_gate_sched
// Brief    : Full-bridge gate scheduler. Turns a raw SPWM compare bit and a
//            half-cycle select into four gate drives, inserting a dead-time
//            on every pattern change so neither leg ever conducts
//            high and low together. An external fault forces all gates off.
// Config   : GATE_FAULT_LATCH_EN - when defined, a fault is latched until
//            fault_clr; when undefined, the fault state follows the fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bridge_gate_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pwm_in,
  input  logic       half_sel,
  input  logic [7:0] dead_cnt,
  input  logic       fault,
  input  logic       fault_clr,
  output logic       gate_ah,
  output logic       gate_al,
  output logic       gate_bh,
  output logic       gate_bl,
  output logic       in_dead,
  output logic       fault_lat
);

  // Gate patterns, bit order {ah, al, bh, bl}
  localparam logic [3:0] c_patOff = 4'b0000;
  localparam logic [3:0] c_patPos = 4'b1001;  // A high, B low
  localparam logic [3:0] c_patNeg = 4'b0110;  // A low, B high
  localparam logic [3:0] c_patFw  = 4'b0101;  // both lows: freewheel

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DEAD = 2'd1,
    ACT  = 2'd2,
    FLT  = 2'd3
  } state_t;

  logic       r_en;
  logic       r_pwm;
  logic       r_half;
  logic       r_fault;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_gates;
  logic [3:0] w_nextGates;
  logic [7:0] r_cnt;
  logic [7:0] w_nextCnt;
  logic [3:0] r_deadTgt;
  logic [3:0] w_nextDeadTgt;

  logic [3:0] w_target;
  logic [7:0] w_load;

  // Input capture: every decision works from these registered copies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en    <= 1'b0;
      r_pwm   <= 1'b0;
      r_half  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_en    <= en;
      r_pwm   <= pwm_in;
      r_half  <= half_sel;
      r_fault <= fault;
    end
  end

  // Desired gate pattern from the registered enable / half-cycle / pwm bits
  always_comb begin
    w_target = c_patOff;
    if (r_en) begin
      if (r_pwm) begin
        w_target = r_half ? c_patPos : c_patNeg;
      end else begin
        w_target = c_patFw;
      end
    end
  end

  // A zero dead-time still costs one DEAD cycle
  assign w_load = (dead_cnt == 8'd0) ? 8'd1 : dead_cnt;

  // Next-state and next-gate decision; fault has priority over everything
  always_comb begin
    w_nextState   = r_state;
    w_nextGates   = r_gates;
    w_nextCnt     = r_cnt;
    w_nextDeadTgt = r_deadTgt;
    if (r_fault) begin
      w_nextState = FLT;
      w_nextGates = c_patOff;
      w_nextCnt   = 8'd0;
    end else begin
      case (r_state)
        OFF: begin
          w_nextGates = c_patOff;
          if (w_target != c_patOff) begin
            w_nextState   = DEAD;
            w_nextCnt     = w_load;
            w_nextDeadTgt = w_target;
          end
        end
        DEAD: begin
          if (w_target != r_deadTgt) begin
            // Target moved mid dead-time: drop anything not in the new
            // target and start the dead-time over
            w_nextGates   = r_gates & w_target;
            w_nextCnt     = w_load;
            w_nextDeadTgt = w_target;
          end else if (r_cnt <= 8'd1) begin
            w_nextCnt = 8'd0;
            if (w_target == c_patOff) begin
              w_nextState = OFF;
              w_nextGates = c_patOff;
            end else begin
              w_nextState = ACT;
              w_nextGates = w_target;
            end
          end else begin
            w_nextCnt = r_cnt - 8'd1;
          end
        end
        ACT: begin
          if (w_target != r_gates) begin
            // Switches leaving the pattern turn off on the DEAD entry edge
            w_nextState   = DEAD;
            w_nextGates   = r_gates & w_target;
            w_nextCnt     = w_load;
            w_nextDeadTgt = w_target;
          end
        end
        FLT: begin
          w_nextGates = c_patOff;
`ifdef GATE_FAULT_LATCH_EN
          if (fault_clr) begin
            w_nextState = OFF;
          end
`else
          w_nextState = OFF;
`endif
        end
        default: begin
          w_nextState = OFF;
          w_nextGates = c_patOff;
          w_nextCnt   = 8'd0;
        end
      endcase
    end
  end

  // State, gate and dead-time registers; reset kills the gates immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= OFF;
      r_gates   <= c_patOff;
      r_cnt     <= 8'd0;
      r_deadTgt <= c_patOff;
    end else begin
      r_state   <= w_nextState;
      r_gates   <= w_nextGates;
      r_cnt     <= w_nextCnt;
      r_deadTgt <= w_nextDeadTgt;
    end
  end

`ifdef GATE_FAULT_LATCH_EN
  logic r_faultLat;

  // Sticky fault flag: set by the registered fault, cleared by fault_clr
  // only once the fault itself has gone away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_faultLat <= 1'b0;
    end else if (r_fault) begin
      r_faultLat <= 1'b1;
    end else if (fault_clr) begin
      r_faultLat <= 1'b0;
    end
  end

  assign fault_lat = r_faultLat;
`else
  logic w_unusedClr;
  assign w_unusedClr = fault_clr;
  assign fault_lat   = r_fault;
`endif

  assign gate_ah = r_gates[3];
  assign gate_al = r_gates[2];
  assign gate_bh = r_gates[1];
  assign gate_bl = r_gates[0];
  assign in_dead = (r_state == DEAD);

endmodule

`default_nettype wire

// File: tb/tb_bridge_gate_sched.sv
// ============================================================================
// Module   : tb_bridge_gate_sched
// Brief    : Directed bench for bridge_gate_sched: table of per-step vectors
//            for dead-time, half-cycle swap, zero dead-time, restart and
//            shutdown, plus hand sequences for fault and mid-ACT reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bridge_gate_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pwm_in;
  logic       half_sel;
  logic [7:0] dead_cnt;
  logic       fault;
  logic       fault_clr;
  logic       gate_ah;
  logic       gate_al;
  logic       gate_bh;
  logic       gate_bl;
  logic       in_dead;
  logic       fault_lat;

  int total = 0;
  int bad = 0;
  int shootErr = 0;

  bridge_gate_sched dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_in    (pwm_in),
    .half_sel  (half_sel),
    .dead_cnt  (dead_cnt),
    .fault     (fault),
    .fault_clr (fault_clr),
    .gate_ah   (gate_ah),
    .gate_al   (gate_al),
    .gate_bh   (gate_bh),
    .gate_bl   (gate_bl),
    .in_dead   (in_dead),
    .fault_lat (fault_lat)
  );

  always #5 clk = ~clk;

  // Shoot-through watch on both clock phases
  always @(posedge clk or negedge clk) begin
    if ((gate_ah & gate_al) | (gate_bh & gate_bl)) shootErr++;
  end

  typedef struct {
    logic       en;
    logic       pwm;
    logic       half;
    logic [7:0] dead;
    int         n;
    logic [3:0] gates;
    logic       inDead;
  } vec_t;

  vec_t vecs[25];

  // Observed outputs packed as {ah, al, bh, bl, in_dead, fault_lat}
  function automatic logic [5:0] obs();
    return {gate_ah, gate_al, gate_bh, gate_bl, in_dead, fault_lat};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b ({ah,al,bh,bl,dead,flt})", name, act, exp);
    end
  endtask

  task automatic chkInt(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    bit on;

    // Step vectors: inputs applied, then n clock edges, then outputs checked
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd0,  0, 4'b0000, 1'b0}; // reset state
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'd4,  1, 4'b0000, 1'b0}; // inputs registered
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'd4,  1, 4'b0000, 1'b1}; // OFF->DEAD
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'd4,  3, 4'b0000, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'd4,  1, 4'b0101, 1'b0}; // freewheel on
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'd4,  1, 4'b0101, 1'b0}; // pwm 0->1 registered
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'd4,  1, 4'b0001, 1'b1}; // al drops, bl stays
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'd4,  3, 4'b0001, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'd4,  1, 4'b1001, 1'b0}; // ah up 4 later
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'd3,  1, 4'b1001, 1'b0}; // half swap
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd3,  1, 4'b0000, 1'b1}; // 1001 & 0110
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'd3,  2, 4'b0000, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'd3,  1, 4'b0110, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 8'd0,  1, 4'b0110, 1'b0}; // zero dead-time
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'd0,  1, 4'b0100, 1'b1}; // one DEAD cycle
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'd0,  1, 4'b0101, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 8'd10, 1, 4'b0101, 1'b0}; // glitch start
    vecs[17] = '{1'b1, 1'b0, 1'b1, 8'd10, 1, 4'b0001, 1'b1}; // DEAD toward 1001
    vecs[18] = '{1'b1, 1'b0, 1'b1, 8'd10, 1, 4'b0001, 1'b1}; // restart toward 0101
    vecs[19] = '{1'b1, 1'b0, 1'b1, 8'd10, 9, 4'b0001, 1'b1}; // reloaded count
    vecs[20] = '{1'b1, 1'b0, 1'b1, 8'd10, 1, 4'b0101, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 8'd2,  1, 4'b0101, 1'b0}; // disable
    vecs[22] = '{1'b0, 1'b0, 1'b1, 8'd2,  1, 4'b0000, 1'b1};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 8'd2,  1, 4'b0000, 1'b1};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 8'd2,  1, 4'b0000, 1'b0}; // back to OFF

    rst = 1'b1; en = 1'b0; pwm_in = 1'b0; half_sel = 1'b0;
    dead_cnt = 8'd0; fault = 1'b0; fault_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].n > 0) @(negedge clk);
      en = vecs[i].en; pwm_in = vecs[i].pwm;
      half_sel = vecs[i].half; dead_cnt = vecs[i].dead;
      for (int j = 0; j < vecs[i].n; j++) tick();
      chk($sformatf("vec%0d", i), obs(), {vecs[i].gates, vecs[i].inDead, 1'b0});
    end

    // Bring the bridge to positive drive with a 2-cycle dead-time
    en = 1'b1; half_sel = 1'b1; pwm_in = 1'b1; dead_cnt = 8'd2;
    repeat (4) tick();
    chk("pre_fault_act", obs(), 6'b1001_0_0);

`ifdef GATE_FAULT_LATCH_EN
    fault = 1'b1;
    tick();
    chk("flt_edge_a", obs(), 6'b1001_0_0);
    tick();
    chk("flt_gates_off", obs(), 6'b0000_0_1);
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("flt_clr_ignored", obs(), 6'b0000_0_1);
    fault = 1'b0;
    repeat (2) tick();
    chk("flt_held", obs(), 6'b0000_0_1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("flt_cleared_off", obs(), 6'b0000_0_0);
    tick();
    chk("flt_to_dead", obs(), 6'b0000_1_0);
    repeat (2) tick();
    chk("flt_recover_act", obs(), 6'b1001_0_0);
`else
    fault = 1'b1;
    tick();
    chk("flt_edge_a", obs(), 6'b1001_0_1);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("flt_hold%0d", j), obs(), 6'b0000_0_1);
    end
    fault = 1'b0;
    tick();
    chk("flt_drop", obs(), 6'b0000_0_0);
    tick();
    chk("flt_to_off", obs(), 6'b0000_0_0);
    tick();
    chk("flt_to_dead", obs(), 6'b0000_1_0);
    repeat (2) tick();
    chk("flt_recover_act", obs(), 6'b1001_0_0);
`endif

    // Reset pulse strictly between clock edges while in ACT
    dead_cnt = 8'd3;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_async", obs(), 6'b0000_0_0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    on = 1'b0;
    while (k < 40 && !on) begin
      tick();
      k++;
      if ({gate_ah, gate_al, gate_bh, gate_bl} != 4'b0000) on = 1'b1;
    end
    chkInt("rst_turnon_seen", int'(on), 1);
    chkInt("rst_turnon_cycles", k, 5);
    chk("rst_turnon_pattern", obs(), 6'b1001_0_0);

    chkInt("shoot_through", shootErr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
